// File: rtl/spi_tx_queue.sv
// spi_tx_queue: command FIFO feeding an SPI master over a req/ack handshake.
// Entries are {dir, len, data}; dir_out is registered on each launch so the
// master's bit order stays stable while the next request is pending.
// Optional macro SPI_TXQ_GAP_EN adds a GAP state that holds req low for
// GAP_CYCLES clocks after every launch.
module spi_tx_queue #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH  = 4,
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [LEN_WIDTH-1:0]  wr_len,
   input  logic                  wr_dir,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  req,
   input  logic                  ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [LEN_WIDTH-1:0]  len_out,
   output logic                  dir_out
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned EW    = DATA_WIDTH + LEN_WIDTH + 1;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [EW-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic [EW-1:0]         head;
   logic                  push;
   logic                  pop;
   state_t                state;
   state_t                state_nxt;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign level    = count;
   assign req      = (state == REQ);
   // Full is the registered value, so a pop on the same edge never frees room.
   assign push     = wr_en & ~full & ~flush;
   assign pop      = (state == REQ) & ack;
   assign head     = mem[rd_ptr];
   assign data_out = head[DATA_WIDTH-1:0];
   assign len_out  = head[DATA_WIDTH +: LEN_WIDTH];

   // Entry storage; intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_dir, wr_len, wr_data};
   end

   // Pointers and fill count; flush clears after any same-edge launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Overflow pulse for a push dropped because the queue was full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else        overflow <= wr_en & full & ~flush;
   end

   // Bit order latched only on a launch edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   dir_out <= 1'b0;
      else if (pop) dir_out <= head[EW-1];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

`ifdef SPI_TXQ_GAP_EN
   logic [7:0] gap_cnt;

   // Post-launch gap counter, loaded on launch and counted down in GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              gap_cnt <= '0;
      else if (pop)            gap_cnt <= 8'(GAP_CYCLES);
      else if (state == GAP)   gap_cnt <= gap_cnt - 1'b1;
   end
`endif

   // Next-state logic; ack takes priority over flush in REQ.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!empty && !flush) state_nxt = REQ;
         REQ: begin
            if (ack) begin
`ifdef SPI_TXQ_GAP_EN
               state_nxt = GAP;
`else
               state_nxt = IDLE;
`endif
            end else if (flush) begin
               state_nxt = IDLE;
            end
         end
`ifdef SPI_TXQ_GAP_EN
         // Leave on the edge where the counter steps from 1 to 0.
         GAP: if (gap_cnt == 8'd1) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Scoreboard bench for spi_tx_queue: randomized pushes/acks/flushes against a
// queue-based reference model; launches are checked by a separate monitor.
module tb_spi_tx_queue;

   localparam int unsigned DW    = 8;
   localparam int unsigned LW    = 4;
   localparam int unsigned DL2   = 2;
   localparam int unsigned GAPC  = 4;
   localparam int unsigned DEPTH = 1 << DL2;
`ifdef SPI_TXQ_GAP_EN
   localparam int unsigned MIN_LOW = GAPC + 1;
`else
   localparam int unsigned MIN_LOW = 1;
`endif

   logic clk = 1'b0;
   logic rst_n, wr_en, wr_dir, flush, ack;
   logic [DW-1:0] wr_data;
   logic [LW-1:0] wr_len;
   logic full, empty, overflow, req, dir_out;
   logic [DL2:0] level;
   logic [DW-1:0] data_out;
   logic [LW-1:0] len_out;

   spi_tx_queue #(
      .DATA_WIDTH(DW),
      .LEN_WIDTH (LW),
      .DEPTH_LOG2(DL2),
      .GAP_CYCLES(GAPC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .wr_len  (wr_len),
      .wr_dir  (wr_dir),
      .flush   (flush),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .overflow(overflow),
      .req     (req),
      .ack     (ack),
      .data_out(data_out),
      .len_out (len_out),
      .dir_out (dir_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          dir;
      logic [LW-1:0] len;
      logic [DW-1:0] data;
   } word_t;

   // Reference model: queued words, expected launches, and req timing rules.
   word_t       mq[$];
   word_t       sb[$];
   bit          req_m, dir_m, ovf_m;
   int unsigned lowcnt, need;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      req_m  = 1'b0;
      dir_m  = 1'b0;
      ovf_m  = 1'b0;
      lowcnt = 1000;
      need   = 1;
   endtask

   // Apply one clock edge to the model using the inputs that were on the pins.
   task automatic model_edge();
      int    cnt_pre  = mq.size();
      bit    full_pre = (cnt_pre == DEPTH);
      word_t w;
      if (req_m && ack && mq.size() > 0) begin
         w = mq.pop_front();
         sb.push_back(w);
         dir_m = w.dir;
      end
      ovf_m = wr_en && full_pre && !flush;
      if (flush) mq.delete();
      else if (wr_en && !full_pre) mq.push_back({wr_dir, wr_len, wr_data});
      if (req_m) begin
         if (ack) begin
            req_m = 1'b0; need = MIN_LOW; lowcnt = 0;
         end else if (flush) begin
            req_m = 1'b0; need = 1; lowcnt = 0;
         end
      end else begin
         lowcnt++;
         if (lowcnt >= need && cnt_pre > 0 && !flush) req_m = 1'b1;
      end
   endtask

   task automatic drive(input int unsigned pw, input int unsigned pa, input int unsigned pf);
      wr_en   = ($urandom_range(99) < pw);
      wr_data = DW'($urandom);
      wr_len  = LW'($urandom);
      wr_dir  = 1'($urandom);
      ack     = ($urandom_range(99) < pa);
      flush   = ($urandom_range(99) < pf);
   endtask

   // Monitor: sample the handshake mid-cycle, compare after the edge.
   bit          en_s, hs;
   logic [DW-1:0] d_s;
   logic [LW-1:0] l_s;
   word_t       mw;
   initial begin
      forever begin
         @(negedge clk);
         en_s = mon_en;
         hs   = req & ack;
         d_s  = data_out;
         l_s  = len_out;
         @(posedge clk);
         #2;
         if (en_s && mon_en) begin
            if (hs) begin
               if (sb.size() == 0) chk("launch_unexpected", 32'd1, 32'd0);
               else begin
                  mw = sb.pop_front();
                  chk("launch_data", 32'(d_s), 32'(mw.data));
                  chk("launch_len", 32'(l_s), 32'(mw.len));
                  chk("launch_dir", 32'(dir_out), 32'(mw.dir));
               end
            end
            chk("missed_launch", sb.size(), 0);
            sb.delete();
            chk("level", 32'(level), mq.size());
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            chk("req", 32'(req), 32'(req_m));
            chk("dir_out", 32'(dir_out), 32'(dir_m));
            if (mq.size() > 0) begin
               chk("head_data", 32'(data_out), 32'(mq[0].data));
               chk("head_len", 32'(len_out), 32'(mq[0].len));
            end
         end
      end
   end

   int unsigned pw_t[4] = '{80, 50, 30, 90};
   int unsigned pa_t[4] = '{ 0, 50, 70, 90};
   int unsigned pf_t[4] = '{ 0,  3, 10,  0};
   int unsigned guard;

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_len = '0; wr_dir = 1'b0;
      flush = 1'b0; ack = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_dir", 32'(dir_out), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            model_edge();
            drive(pw_t[ph], pa_t[ph], pf_t[ph]);
         end
         if (ph == 1) begin
            // Asynchronous reset in the middle of traffic.
            @(posedge clk);
            #1;
            model_edge();
            mon_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            chk("arst_req", 32'(req), 32'd0);
            chk("arst_level", 32'(level), 32'd0);
            chk("arst_empty", 32'(empty), 32'd1);
            chk("arst_dir", 32'(dir_out), 32'd0);
            wr_en = 1'b0; ack = 1'b0; flush = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            model_reset();
            rst_n  = 1'b1;
            mon_en = 1'b1;
         end
      end

      // Drain: acknowledge every request until the model is idle.
      guard = 0;
      while ((mq.size() > 0 || req_m) && guard < 200) begin
         @(posedge clk);
         #1;
         model_edge();
         wr_en = 1'b0; flush = 1'b0; ack = 1'b1;
         guard++;
      end
      chk("drain_timeout", 32'(guard >= 200), 32'd0);
      ack = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         model_edge();
      end
      @(posedge clk);
      #3;
      chk("final_empty", 32'(empty), 32'd1);
      chk("final_req", 32'(req), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_tx_queue.md
# spi_tx_queue

Command queue that sits directly upstream of the SPI master. Software/control logic pushes transfer words (data, length, bit order) into a small FIFO; the block pops them one at a time and presents each to the SPI master over its req/ack handshake, holding the bit-order line stable for the whole serial transfer. It decouples bursty producers from the slow, serialised SPI link and reports full, empty, fill level and overflow.

## Interface
- DATA_WIDTH, 8, width of one transfer word; must match the SPI master.
- LEN_WIDTH, 4, width of the length field; must match the SPI master.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4); legal range 1..6.
- GAP_CYCLES, 4, idle clk cycles inserted after each launch; used only with SPI_TXQ_GAP_EN; legal range 1..255.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  push strobe, one entry per cycle high.
- wr_data  input  DATA_WIDTH  word to transmit.
- wr_len  input  LEN_WIDTH  length field carried with the word.
- wr_dir  input  1  bit order carried with the word (0 = LSB first, 1 = MSB first).
- flush  input  1  synchronous clear of all queued, not-yet-launched entries.
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  DEPTH_LOG2+1  current entry count.
- overflow  output  1  one-cycle pulse when wr_en is dropped because full.
- req  output  1  transfer request to SPI master.
- ack  input  1  one-cycle acknowledge from SPI master; word captured on that edge.
- data_out  output  DATA_WIDTH  head entry data, to master data_in.
- len_out  output  LEN_WIDTH  head entry length, to master len_data.
- dir_out  output  1  registered bit order of the last launched word, to master dir_transfer.

## Operation
- FIFO: circular buffer, 2^DEPTH_LOG2 entries of {dir, len, data}; write and read pointers DEPTH_LOG2 bits, wrap modulo depth; count of DEPTH_LOG2+1 bits.
- Push accepted iff wr_en & ~full (registered full at that edge); a push in the same cycle as a pop while full is still rejected. Rejected push: entry discarded, overflow pulses the next cycle.
- Pop occurs on the edge where req & ack; push and pop on the same edge leave level unchanged.
- data_out/len_out are combinational reads of the head entry; valid whenever ~empty.
- FSM states: IDLE, REQ, GAP (GAP exists only with SPI_TXQ_GAP_EN).
- IDLE -> REQ when ~empty & ~flush.
- REQ: req = 1. On ack: pop, load dir_out from head dir, go to GAP (macro on) or IDLE (macro off). On flush without ack: go IDLE, req drops.
- ack with flush in the same cycle: the ack wins (word is launched, popped, dir_out updated), then remaining entries are cleared.
- ack while not in REQ is ignored.
- dir_out changes only on a launch edge; it is never taken from the head combinationally, so the master's bit order is stable while a previous word is still shifting and the next req is pending.
- flush: pointers and count to 0 on that edge; a push in the same cycle is discarded without overflow.

## Timing
- Reset values: req 0, dir_out 0, full 0, empty 1, level 0, overflow 0, state IDLE; FIFO storage not reset.
- Push into empty FIFO at edge N: empty falls after N, state REQ after N+1, req high from cycle N+1 edge onward (2-cycle push-to-req latency).
- req stays high until and including the ack cycle; falls on the edge after ack.
- Minimum req-low time between launches: 1 cycle (macro off), GAP_CYCLES+1 cycles (macro on).
- Reset mid-transfer: req drops immediately (asynchronous), queue emptied.

## Configuration
- SPI_TXQ_GAP_EN defined: GAP state with an 8-bit down-counter loaded with GAP_CYCLES on launch; GAP -> IDLE when counter reaches 0; flush in GAP does not shorten the gap.
- Undefined: no GAP state, no counter; REQ -> IDLE directly on ack; GAP_CYCLES ignored.

## Test plan
- Reset, then push {dir=1,len=8,data=0xA5} -> req high 2 cycles later, data_out=0xA5; ack pulse -> dir_out=1, empty=1, req low next cycle.
- Push 5 words into depth-4 queue without ack -> full=1, level=4, one overflow pulse on 5th push; words popped in order 0x01..0x04.
- Push and ack on same edge with level=2 -> level stays 2, head advances.
- Queue 3 words, assert flush during REQ without ack -> req low next cycle, level=0, dir_out unchanged.
- flush and ack same cycle with 3 queued -> first word launched (dir_out updated), level=0 after edge.
- With SPI_TXQ_GAP_EN, GAP_CYCLES=4, 2 words queued, ack immediately -> req low exactly 5 cycles between launches.
